ysyx_210238_pipe_ctrl: RTL and testbench

Pipeline sequencing controller for the five-stage core (IF/ID/EX/LS/WB). It consumes the hazard-detect flags, ID-stage branch redirects and the fetch/memory busy signals, and it issues per-stage stall, flush and PC-write controls. A small FSM discards an instruction fetch that is already in flight when a redirect occurs. A saturating counter records stall cycles for performance monitoring.

---
 rtl/ysyx_210238_pipe_ctrl_pkg.sv | 12 +
 rtl/ysyx_210238_sat_cnt.sv | 27 ++
 rtl/ysyx_210238_pipe_ctrl.sv | 127 ++++++++++++
 tb/tb_ysyx_210238_pipe_ctrl.sv | 166 ++++++++++++++++
 4 files changed

// File: rtl/ysyx_210238_pipe_ctrl_pkg.sv
// rtl/ysyx_210238_pipe_ctrl_pkg.sv - shared types and defaults for the pipeline controller
// Contents: fetch-discard FSM state encoding, default stall-counter width.
package ysyx_210238_pipe_ctrl_pkg;

  typedef enum logic {
    ST_RUN  = 1'b0,
    ST_DROP = 1'b1
  } pipe_state_e;

  localparam int CNT_W_DEF = 32;

endpackage

// File: rtl/ysyx_210238_sat_cnt.sv
// rtl/ysyx_210238_sat_cnt.sv - saturating up-counter with enable
// Ports:
//   clock, reset : rising-edge clock, asynchronous active-high reset
//   i_en         : count one when high
//   o_cnt        : current count, holds at all-ones
module ysyx_210238_sat_cnt #(
  parameter int W = 32
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         i_en,
  output logic [W-1:0] o_cnt
);

  logic [W-1:0] r_cnt;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_cnt <= '0;
    end else if (i_en && (r_cnt != {W{1'b1}})) begin
      r_cnt <= r_cnt + W'(1);
    end
  end

  assign o_cnt = r_cnt;

endmodule

// File: rtl/ysyx_210238_pipe_ctrl.sv
// rtl/ysyx_210238_pipe_ctrl.sv - five-stage pipeline stall/flush/PC-write sequencing
// Ports:
//   clock, reset          : rising-edge clock, asynchronous active-high reset
//   i_load_use            : load-use data hazard between ID and EX
//   i_ctrl_load_use       : ID branch depends on a load in EX
//   i_redirect            : taken branch/jump resolved in ID
//   i_if_busy, i_if_done  : fetch outstanding / fetch response this cycle
//   i_ls_busy             : LS data access outstanding
//   o_pc_wen, o_pc_sel_redirect : PC update enable and source select
//   o_*_stall, o_*_flush  : per pipeline-register hold / bubble controls
//   o_drop_fetch          : discard the fetch response arriving this cycle
//   o_stall_cnt           : saturating count of IF/ID stall cycles
module ysyx_210238_pipe_ctrl
  import ysyx_210238_pipe_ctrl_pkg::*;
#(
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             i_load_use,
  input  logic             i_ctrl_load_use,
  input  logic             i_redirect,
  input  logic             i_if_busy,
  input  logic             i_if_done,
  input  logic             i_ls_busy,
  output logic             o_pc_wen,
  output logic             o_pc_sel_redirect,
  output logic             o_if_id_stall,
  output logic             o_id_ex_stall,
  output logic             o_ex_ls_stall,
  output logic             o_ls_wb_stall,
  output logic             o_if_id_flush,
  output logic             o_id_ex_flush,
  output logic             o_ls_wb_flush,
  output logic             o_drop_fetch,
  output logic [CNT_W-1:0] o_stall_cnt
);

  pipe_state_e r_state;
  pipe_state_e w_state_nxt;
  logic        w_load_use;

  assign w_load_use = i_load_use | i_ctrl_load_use;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state <= ST_RUN;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt       = r_state;
    o_pc_wen          = 1'b0;
    o_pc_sel_redirect = 1'b0;
    o_if_id_stall     = 1'b0;
    o_id_ex_stall     = 1'b0;
    o_ex_ls_stall     = 1'b0;
    o_ls_wb_stall     = 1'b0;
    o_if_id_flush     = 1'b0;
    o_id_ex_flush     = 1'b0;
    o_ls_wb_flush     = 1'b0;
    o_drop_fetch      = 1'b0;
    // Outputs are held low for the whole reset window, not just at the edge.
    if (!reset) begin
      if (r_state == ST_RUN) begin
        if (i_ls_busy) begin
          // Redirect/load-use are re-presented by ID once the pipe moves again.
          o_if_id_stall = 1'b1;
          o_id_ex_stall = 1'b1;
          o_ex_ls_stall = 1'b1;
          o_ls_wb_stall = 1'b1;
          o_ls_wb_flush = 1'b1;
        end else if (w_load_use) begin
          o_if_id_stall = 1'b1;
          o_id_ex_flush = 1'b1;
        end else if (i_redirect) begin
          o_pc_wen          = 1'b1;
          o_pc_sel_redirect = 1'b1;
          o_if_id_flush     = 1'b1;
          // A response landing now belongs to the wrong path: drop it in place.
          o_drop_fetch      = i_if_done;
          if (i_if_busy && !i_if_done) begin
            w_state_nxt = ST_DROP;
          end
        end else if (i_if_busy) begin
          o_if_id_flush = 1'b1;
        end else begin
          o_pc_wen = 1'b1;
        end
      end else begin
        // The stale fetch must be discarded whatever else the pipe is doing.
        o_drop_fetch = i_if_done;
        if (i_if_done) begin
          w_state_nxt = ST_RUN;
        end
        if (i_ls_busy) begin
          o_if_id_stall = 1'b1;
          o_id_ex_stall = 1'b1;
          o_ex_ls_stall = 1'b1;
          o_ls_wb_stall = 1'b1;
          o_ls_wb_flush = 1'b1;
        end else if (w_load_use) begin
          o_if_id_stall = 1'b1;
          o_id_ex_flush = 1'b1;
        end else begin
          o_if_id_flush = 1'b1;
          if (i_redirect) begin
            o_pc_wen          = 1'b1;
            o_pc_sel_redirect = 1'b1;
          end
        end
      end
    end
  end

  ysyx_210238_sat_cnt #(
    .W(CNT_W)
  ) u_stall_cnt (
    .clock (clock),
    .reset (reset),
    .i_en  (o_if_id_stall),
    .o_cnt (o_stall_cnt)
  );

endmodule

// File: tb/tb_ysyx_210238_pipe_ctrl.sv
// tb/tb_ysyx_210238_pipe_ctrl.sv - scoreboard bench for ysyx_210238_pipe_ctrl
module tb_ysyx_210238_pipe_ctrl;

  typedef struct packed {
    logic [9:0]  ctrl;
    logic [31:0] cnt;
    logic [2:0]  cnt3;
  } exp_t;

  // {pc_wen, sel, if_id_st, id_ex_st, ex_ls_st, ls_wb_st, if_id_fl, id_ex_fl, ls_wb_fl, drop}
  localparam logic [9:0] C_ZERO  = 10'b00_0000_000_0;
  localparam logic [9:0] C_IDLE  = 10'b10_0000_000_0;
  localparam logic [9:0] C_LU    = 10'b00_1000_010_0;
  localparam logic [9:0] C_LS    = 10'b00_1111_001_0;
  localparam logic [9:0] C_REDIR = 10'b11_0000_100_0;
  localparam logic [9:0] C_RDROP = 10'b11_0000_100_1;
  localparam logic [9:0] C_FLUSH = 10'b00_0000_100_0;
  localparam logic [9:0] C_DROPD = 10'b00_0000_100_1;

  logic clock = 1'b0;
  logic reset = 1'b1;
  logic i_load_use = 1'b0, i_ctrl_load_use = 1'b0, i_redirect = 1'b0;
  logic i_if_busy = 1'b0, i_if_done = 1'b0, i_ls_busy = 1'b0;

  logic o_pc_wen, o_pc_sel_redirect, o_if_id_stall, o_id_ex_stall, o_ex_ls_stall, o_ls_wb_stall;
  logic o_if_id_flush, o_id_ex_flush, o_ls_wb_flush, o_drop_fetch;
  logic [31:0] o_stall_cnt;

  logic s_pc_wen, s_sel, s_if_id_st, s_id_ex_st, s_ex_ls_st, s_ls_wb_st;
  logic s_if_id_fl, s_id_ex_fl, s_ls_wb_fl, s_drop;
  logic [2:0] s_stall_cnt;

  always #5 clock = ~clock;

  ysyx_210238_pipe_ctrl #(.CNT_W(32)) dut (
    .clock(clock), .reset(reset),
    .i_load_use(i_load_use), .i_ctrl_load_use(i_ctrl_load_use), .i_redirect(i_redirect),
    .i_if_busy(i_if_busy), .i_if_done(i_if_done), .i_ls_busy(i_ls_busy),
    .o_pc_wen(o_pc_wen), .o_pc_sel_redirect(o_pc_sel_redirect),
    .o_if_id_stall(o_if_id_stall), .o_id_ex_stall(o_id_ex_stall),
    .o_ex_ls_stall(o_ex_ls_stall), .o_ls_wb_stall(o_ls_wb_stall),
    .o_if_id_flush(o_if_id_flush), .o_id_ex_flush(o_id_ex_flush),
    .o_ls_wb_flush(o_ls_wb_flush), .o_drop_fetch(o_drop_fetch),
    .o_stall_cnt(o_stall_cnt)
  );

  ysyx_210238_pipe_ctrl #(.CNT_W(3)) dut3 (
    .clock(clock), .reset(reset),
    .i_load_use(i_load_use), .i_ctrl_load_use(i_ctrl_load_use), .i_redirect(i_redirect),
    .i_if_busy(i_if_busy), .i_if_done(i_if_done), .i_ls_busy(i_ls_busy),
    .o_pc_wen(s_pc_wen), .o_pc_sel_redirect(s_sel),
    .o_if_id_stall(s_if_id_st), .o_id_ex_stall(s_id_ex_st),
    .o_ex_ls_stall(s_ex_ls_st), .o_ls_wb_stall(s_ls_wb_st),
    .o_if_id_flush(s_if_id_fl), .o_id_ex_flush(s_id_ex_fl),
    .o_ls_wb_flush(s_ls_wb_fl), .o_drop_fetch(s_drop),
    .o_stall_cnt(s_stall_cnt)
  );

  logic [9:0] act_ctrl;
  logic [9:0] act_ctrl3;
  assign act_ctrl  = {o_pc_wen, o_pc_sel_redirect, o_if_id_stall, o_id_ex_stall, o_ex_ls_stall,
                      o_ls_wb_stall, o_if_id_flush, o_id_ex_flush, o_ls_wb_flush, o_drop_fetch};
  assign act_ctrl3 = {s_pc_wen, s_sel, s_if_id_st, s_id_ex_st, s_ex_ls_st,
                      s_ls_wb_st, s_if_id_fl, s_id_ex_fl, s_ls_wb_fl, s_drop};

  exp_t        sb_q[$];
  logic        mon_en = 1'b0;
  int          n_vec = 0;
  int          n_bad = 0;
  int          vec_id = 0;
  logic [31:0] cnt_m = 32'd0;
  logic [2:0]  cnt3_m = 3'd0;

  always @(negedge clock) begin
    if (mon_en && sb_q.size() > 0) begin
      exp_t e;
      e = sb_q.pop_front();
      n_vec = n_vec + 1;
      if (act_ctrl !== e.ctrl) begin
        n_bad = n_bad + 1;
        $display("FAIL ctrl vec%0d: got %b expected %b", vec_id, act_ctrl, e.ctrl);
      end
      if (act_ctrl3 !== e.ctrl) begin
        n_bad = n_bad + 1;
        $display("FAIL ctrl_w3 vec%0d: got %b expected %b", vec_id, act_ctrl3, e.ctrl);
      end
      if (o_stall_cnt !== e.cnt) begin
        n_bad = n_bad + 1;
        $display("FAIL stall_cnt vec%0d: got %0d expected %0d", vec_id, o_stall_cnt, e.cnt);
      end
      if (s_stall_cnt !== e.cnt3) begin
        n_bad = n_bad + 1;
        $display("FAIL stall_cnt_w3 vec%0d: got %0d expected %0d", vec_id, s_stall_cnt, e.cnt3);
      end
    end
  end

  // inputs: {rst, load_use, ctrl_load_use, redirect, if_busy, if_done, ls_busy}
  task automatic apply(input logic [6:0] in, input logic [9:0] exp_ctrl);
    exp_t e;
    @(posedge clock);
    #1;
    {reset, i_load_use, i_ctrl_load_use, i_redirect, i_if_busy, i_if_done, i_ls_busy} = in;
    vec_id = vec_id + 1;
    if (in[6]) begin
      cnt_m  = 32'd0;
      cnt3_m = 3'd0;
    end
    e.ctrl = exp_ctrl;
    e.cnt  = cnt_m;
    e.cnt3 = cnt3_m;
    sb_q.push_back(e);
    mon_en = 1'b1;
    if (exp_ctrl[7]) begin
      cnt_m = cnt_m + 32'd1;
      if (cnt3_m != 3'd7) cnt3_m = cnt3_m + 3'd1;
    end
  endtask

  initial begin
    // reset holds everything low even with hazards asserted
    apply(7'b1_0010_01, C_ZERO);
    apply(7'b0_0000_00, C_IDLE);
    // single load-use bubble
    apply(7'b0_1000_00, C_LU);
    apply(7'b0_0000_00, C_IDLE);
    // control load-use beats a redirect
    apply(7'b0_0110_00, C_LU);
    // redirect with fetch in flight: DROP for 3 cycles, response dropped at cycle 3
    apply(7'b0_0011_00, C_REDIR);
    apply(7'b0_0000_00, C_FLUSH);
    apply(7'b0_0000_00, C_FLUSH);
    apply(7'b0_0000_10, C_DROPD);
    apply(7'b0_0000_00, C_IDLE);
    // ls_busy for 5 cycles overrides redirect and load-use
    for (int i = 0; i < 5; i++) apply(7'b0_1010_01, C_LS);
    apply(7'b0_0000_00, C_IDLE);
    // long stall: 3-bit counter saturates at 7
    for (int i = 0; i < 10; i++) apply(7'b0_1000_00, C_LU);
    apply(7'b0_0000_00, C_IDLE);
    // redirect with response in the same cycle: dropped directly, stays RUN
    apply(7'b0_0011_10, C_RDROP);
    apply(7'b0_0000_00, C_IDLE);
    // plain fetch busy in RUN
    apply(7'b0_0001_00, C_FLUSH);
    // redirect into DROP, second redirect in DROP, then reset mid-DROP
    apply(7'b0_0011_00, C_REDIR);
    apply(7'b0_0010_00, C_REDIR);
    apply(7'b0_0000_00, C_FLUSH);
    apply(7'b1_0000_00, C_ZERO);
    apply(7'b0_0000_00, C_IDLE);
    apply(7'b0_0000_00, C_IDLE);
    @(posedge clock);
    #1;
    for (int k = 0; k < 5 && sb_q.size() > 0; k++) @(negedge clock);
    #1;
    if (sb_q.size() != 0) begin
      n_bad = n_bad + 1;
      $display("FAIL drain: %0d entries left, expected 0", sb_q.size());
    end
    mon_en = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
